// File: rtl/fc_pkg.sv
// Shared definitions for the frame composer: frame-buffer geometry, sprite size,
// start-strobe length, FSM state type and address-decoding helpers.
package fc_pkg;

    localparam int unsigned FB_AW     = 11;
    localparam int unsigned FB_BYTES  = 2048;
    localparam int unsigned SPR_W     = 16;
    localparam int unsigned START_LEN = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRender,
        StWaitSwap,
        StStart
    } fc_state_e;

    // Byte address is {x[4:0], y[5:0]}; the global column is {x[4:3], y}.
    function automatic logic [7:0] fb_gcol(input logic [FB_AW-1:0] addr);
        return {addr[10:9], addr[5:0]};
    endfunction

    // Page (group of 8 pixel rows) is x[2:0].
    function automatic logic [2:0] fb_page(input logic [FB_AW-1:0] addr);
        return addr[8:6];
    endfunction

endpackage

// File: rtl/fc_fb_ram.sv
// Double-banked 2 x 2048 x 8 frame-buffer RAM.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset (read register only)
//   we_i, wbank_i, waddr_i,
//   wdata_i                  write port (bank select = back bank)
//   rbank_i, raddr_i         read port address (bank select = front bank)
//   rdata_o                  registered read data, 1-cycle latency
module fc_fb_ram
    import fc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic             wbank_i,
    input  logic [FB_AW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic             rbank_i,
    input  logic [FB_AW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [2*FB_BYTES];
    logic [7:0] rdata_q;

    // Contents are never cleared; every frame rewrites the whole back bank.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wbank_i, waddr_i}] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[{rbank_i, raddr_i}];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_composer.sv
// Frame composer: renders up to N_SPR 16x16 sprites into the back bank of a
// double-buffered 2048-byte frame buffer, swaps banks once the driver is idle and
// pulses the driver's start strobe. The front bank serves the driver read port.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   frame_req_i                     request a new frame (accepted in idle only)
//   spr_valid_i/x_i/y_i/id_i        per-slot sprite descriptors (packed, slot k at low end)
//   rom_addr_o, rom_data_i          sprite ROM {id, col}, data 1 cycle later
//   drv_addr_i, drv_data_o          driver read port, registered
//   drv_idle_i                      driver is halted
//   start_o                         4-cycle start strobe
//   busy_o                          frame in progress
module frame_composer
    import fc_pkg::*;
#(
    parameter int unsigned N_SPR = 4,
    parameter int unsigned ID_W  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  frame_req_i,
    input  logic [N_SPR-1:0]      spr_valid_i,
    input  logic [N_SPR*8-1:0]    spr_x_i,
    input  logic [N_SPR*6-1:0]    spr_y_i,
    input  logic [N_SPR*ID_W-1:0] spr_id_i,
    output logic [ID_W+3:0]       rom_addr_o,
    input  logic [SPR_W-1:0]      rom_data_i,
    input  logic [FB_AW-1:0]      drv_addr_i,
    output logic [7:0]            drv_data_o,
    input  logic                  drv_idle_i,
    output logic                  start_o,
    output logic                  busy_o
);

    localparam int unsigned CYC_W  = $clog2(N_SPR + 2);
    localparam int unsigned STRB_W = $clog2(START_LEN);

    fc_state_e           state_q, state_d;
    logic [FB_AW-1:0]    addr_q, addr_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [7:0]          acc_q, acc_d;
    logic                front_q, front_d;
    logic                pend_q, pend_d;
    logic [STRB_W-1:0]   strb_q, strb_d;

    logic [N_SPR-1:0]      valid_q;
    logic [N_SPR*8-1:0]    x_q;
    logic [N_SPR*6-1:0]    y_q;
    logic [N_SPR*ID_W-1:0] id_q;

    logic       accept;
    logic       we;
    logic [7:0] gcol;
    logic [2:0] page;
    logic [7:0] col;
    logic [7:0] contrib;

    assign accept = (state_q == StIdle) && frame_req_i;
    assign gcol   = fb_gcol(addr_q);
    assign page   = fb_page(addr_q);

    // ROM address for slot k is presented in byte-cycle k.
    always_comb begin
        rom_addr_o = '0;
        col        = '0;
        if (state_q == StRender) begin
            for (int k = 0; k < int'(N_SPR); k++) begin
                if (int'(cyc_q) == k) begin
                    col        = gcol - x_q[8*k +: 8];
                    rom_addr_o = {id_q[ID_W*k +: ID_W], col[3:0]};
                end
            end
        end
    end

    // Slot k's word returns in byte-cycle k+1; no horizontal wrap, rows >= 64 fall off.
    always_comb begin
        contrib = '0;
        if (state_q == StRender) begin
            for (int k = 0; k < int'(N_SPR); k++) begin
                if (int'(cyc_q) == k + 1) begin
                    if (valid_q[k] &&
                        ({1'b0, gcol} >= {1'b0, x_q[8*k +: 8]}) &&
                        ({1'b0, gcol} <= ({1'b0, x_q[8*k +: 8]} + 9'd15))) begin
                        contrib = 8'(({48'b0, rom_data_i} << y_q[6*k +: 6]) >> {page, 3'b000});
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        front_d = front_q;
        pend_d  = pend_q;
        strb_d  = strb_q;
        we      = 1'b0;

        // A strobe stays outstanding until the driver is seen leaving idle.
        if (state_q == StStart) begin
            pend_d = 1'b1;
        end else if (!drv_idle_i) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_req_i) begin
                    state_d = StRender;
                    addr_d  = '0;
                    cyc_d   = '0;
                    acc_d   = '0;
                end
            end
            StRender: begin
                if (cyc_q == CYC_W'(N_SPR + 1)) begin
                    we     = 1'b1;
                    cyc_d  = '0;
                    acc_d  = '0;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == FB_AW'(FB_BYTES - 1)) begin
                        state_d = StWaitSwap;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                    acc_d = acc_q | contrib;
                end
            end
            StWaitSwap: begin
                if (drv_idle_i && !pend_q) begin
                    front_d = ~front_q;
                    strb_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (strb_q == STRB_W'(START_LEN - 1)) begin
                    state_d = StIdle;
                end else begin
                    strb_d = strb_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cyc_q   <= '0;
            acc_q   <= '0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            strb_q  <= strb_d;
        end
    end

    // Sprite descriptors are frozen for the whole frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= '0;
        end else if (accept) begin
            valid_q <= spr_valid_i;
            x_q     <= spr_x_i;
            y_q     <= spr_y_i;
            id_q    <= spr_id_i;
        end
    end

    assign start_o = (state_q == StStart);
    assign busy_o  = (state_q != StIdle);

    fc_fb_ram u_fb_ram (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .we_i    (we),
        .wbank_i (~front_q),
        .waddr_i (addr_q),
        .wdata_i (acc_q),
        .rbank_i (front_q),
        .raddr_i (drv_addr_i),
        .rdata_o (drv_data_o)
    );

endmodule

// File: tb/tb_frame_composer.sv
// Directed self-checking bench for frame_composer with a registered sprite ROM model.
module tb_frame_composer;

    localparam int unsigned N_SPR = 4;
    localparam int unsigned ID_W  = 3;

    logic                  clk;
    logic                  rstn;
    logic                  frame_req_i;
    logic [N_SPR-1:0]      spr_valid_i;
    logic [N_SPR*8-1:0]    spr_x_i;
    logic [N_SPR*6-1:0]    spr_y_i;
    logic [N_SPR*ID_W-1:0] spr_id_i;
    logic [ID_W+3:0]       rom_addr_o;
    logic [15:0]           rom_data_i;
    logic [10:0]           drv_addr_i;
    logic [7:0]            drv_data_o;
    logic                  drv_idle_i;
    logic                  start_o;
    logic                  busy_o;

    logic [15:0] rom [2**(ID_W+4)];

    int n_tests = 0;
    int n_fail  = 0;

    frame_composer #(
        .N_SPR (N_SPR),
        .ID_W  (ID_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_req_i (frame_req_i),
        .spr_valid_i (spr_valid_i),
        .spr_x_i     (spr_x_i),
        .spr_y_i     (spr_y_i),
        .spr_id_i    (spr_id_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .drv_addr_i  (drv_addr_i),
        .drv_data_o  (drv_data_o),
        .drv_idle_i  (drv_idle_i),
        .start_o     (start_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic v, input logic [7:0] x,
                            input logic [5:0] y, input logic [ID_W-1:0] id);
        spr_valid_i[k]         = v;
        spr_x_i[8*k +: 8]      = x;
        spr_y_i[6*k +: 6]      = y;
        spr_id_i[ID_W*k +: ID_W] = id;
    endtask

    task automatic clear_slots();
        spr_valid_i = '0;
        spr_x_i     = '0;
        spr_y_i     = '0;
        spr_id_i    = '0;
    endtask

    task automatic rd(input logic [10:0] a, output logic [7:0] d);
        drv_addr_i = a;
        @(posedge clk);
        #1;
        d = drv_data_o;
    endtask

    task automatic rd_check(input string tag, input logic [10:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(tag, {24'b0, d}, {24'b0, exp});
    endtask

    // Pulse a request, measure cycles to start_o and strobe length, then mimic the
    // driver leaving idle for one cycle so the outstanding strobe is retired.
    task automatic run_frame(output int nbusy, output int nstart);
        frame_req_i = 1'b1;
        @(posedge clk);
        #1;
        frame_req_i = 1'b0;
        check("busy_after_req", {31'b0, busy_o}, 32'd1);
        nbusy = 0;
        while (!start_o && nbusy < 20000) begin
            @(posedge clk);
            #1;
            nbusy++;
        end
        nstart = 0;
        while (start_o && nstart < 10) begin
            @(posedge clk);
            #1;
            nstart++;
        end
        drv_idle_i = 1'b0;
        @(posedge clk);
        #1;
        drv_idle_i = 1'b1;
    endtask

    // Frame 2 image: sprite at (0,0) fills pages 0/1 cols 0..15; clipped sprite at
    // (250,60) leaves only rows 60..63 in page 7 of cols 250..255.
    function automatic logic [7:0] exp_f2(input int a);
        if ((a >= 'h000 && a <= 'h00F) || (a >= 'h040 && a <= 'h04F)) return 8'hFF;
        if (a >= 'h7FA && a <= 'h7FF) return 8'hF0;
        return 8'h00;
    endfunction

    task automatic scan(input int mode, input string tag);
        int mism;
        logic [7:0] d;
        logic [7:0] e;
        mism = 0;
        for (int a = 0; a < 2048; a++) begin
            rd(11'(a), d);
            e = (mode == 0) ? 8'h00 : exp_f2(a);
            if (d !== e) mism++;
        end
        check(tag, 32'(mism), 32'd0);
    endtask

    task automatic frame_checks(input string tag, input int nb, input int ns);
        check({tag, "_busy_len"}, {31'b0, (nb >= 12288 && nb <= 12290)}, 32'd1);
        check({tag, "_start_len"}, 32'(ns), 32'd4);
        check({tag, "_busy_low"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        int nb;
        int ns;
        int cnt;
        logic saw_start;

        for (int i = 0; i < 2**(ID_W+4); i++) rom[i] = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            rom[c]      = 16'hFFFF;
            rom[16 + c] = 16'h00F0;
            rom[32 + c] = 16'h0F00;
        end

        rstn        = 1'b0;
        frame_req_i = 1'b0;
        drv_addr_i  = '0;
        drv_idle_i  = 1'b1;
        clear_slots();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_start", {31'b0, start_o}, 32'd0);
        check("rst_drv_data", {24'b0, drv_data_o}, 32'd0);
        check("rst_rom_addr", {25'b0, rom_addr_o}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Empty frame.
        run_frame(nb, ns);
        frame_checks("f1", nb, ns);
        scan(0, "f1_scan_zero");

        // Unclipped sprite plus one clipped at the right/bottom corner.
        clear_slots();
        set_slot(0, 1'b1, 8'd0, 6'd0, 3'd0);
        set_slot(1, 1'b1, 8'd250, 6'd60, 3'd0);
        run_frame(nb, ns);
        frame_checks("f2", nb, ns);
        scan(1, "f2_scan");
        rd_check("f2_0x000", 11'h000, 8'hFF);
        rd_check("f2_0x04F", 11'h04F, 8'hFF);
        rd_check("f2_0x63A", 11'h63A, 8'h00);
        rd_check("f2_0x7FA", 11'h7FA, 8'hF0);
        rd_check("f2_0x7F9", 11'h7F9, 8'h00);

        // Vertical offset, OR of two slots, and an invalid slot that must not draw.
        clear_slots();
        set_slot(0, 1'b1, 8'd0, 6'd4, 3'd0);
        set_slot(1, 1'b1, 8'd100, 6'd0, 3'd1);
        set_slot(2, 1'b1, 8'd100, 6'd0, 3'd2);
        set_slot(3, 1'b0, 8'd100, 6'd0, 3'd0);
        run_frame(nb, ns);
        frame_checks("f3", nb, ns);
        rd_check("f3_y4_0x000", 11'h000, 8'hF0);
        rd_check("f3_y4_0x00F", 11'h00F, 8'hF0);
        rd_check("f3_y4_0x010", 11'h010, 8'h00);
        rd_check("f3_y4_0x040", 11'h040, 8'hFF);
        rd_check("f3_y4_0x080", 11'h080, 8'h0F);
        rd_check("f3_y4_0x08F", 11'h08F, 8'h0F);
        rd_check("f3_or_0x224", 11'h224, 8'hF0);
        rd_check("f3_or_0x233", 11'h233, 8'hF0);
        rd_check("f3_or_0x264", 11'h264, 8'h0F);
        rd_check("f3_or_0x273", 11'h273, 8'h0F);
        rd_check("f3_or_0x2A4", 11'h2A4, 8'h00);

        // Driver not idle at render end: no swap, no strobe until idle returns.
        clear_slots();
        drv_idle_i  = 1'b0;
        frame_req_i = 1'b1;
        @(posedge clk);
        #1;
        frame_req_i = 1'b0;
        saw_start = 1'b0;
        for (int i = 0; i < 12400; i++) begin
            @(posedge clk);
            #1;
            if (start_o) saw_start = 1'b1;
        end
        check("noidle_no_start", {31'b0, saw_start}, 32'd0);
        check("noidle_busy", {31'b0, busy_o}, 32'd1);
        rd_check("noidle_old_data", 11'h000, 8'hF0);
        drv_idle_i = 1'b1;
        cnt = 0;
        while (!start_o && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("idle_swap_latency", 32'(cnt), 32'd1);
        ns = 0;
        while (start_o && ns < 10) begin
            @(posedge clk);
            #1;
            ns++;
        end
        check("idle_start_len", 32'(ns), 32'd4);
        drv_idle_i = 1'b0;
        @(posedge clk);
        #1;
        drv_idle_i = 1'b1;
        rd_check("idle_new_data", 11'h000, 8'h00);

        // Asynchronous reset in the middle of a render.
        frame_req_i = 1'b1;
        @(posedge clk);
        #1;
        frame_req_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("midrst_busy_before", {31'b0, busy_o}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_start", {31'b0, start_o}, 32'd0);
        check("midrst_drv_data", {24'b0, drv_data_o}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Recovery frame after reset.
        clear_slots();
        set_slot(0, 1'b1, 8'd0, 6'd0, 3'd0);
        run_frame(nb, ns);
        frame_checks("f5", nb, ns);
        rd_check("f5_0x000", 11'h000, 8'hFF);
        rd_check("f5_0x050", 11'h050, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
